attn_qkv_loader: RTL
====================

// Module: attn_qkv_loader
// PURPOSE
//  Upstream stage of pe_8x8_top. Accepts a serial stream of 16-bit FP words over valid/ready.
//  Assembles three 512-bit operand buses (key, query, value) from that stream.
//  Sequences pe_8x8_top enable/reset, then holds the buses stable until the array reports all_done.
//  Replaces testbench-style bulk bus preload with a streamed, handshaked load path.
// PARAMETERS
//  DATA_W          16    width of one element word
//  N_WORDS         32    words per operand bus; bus width = DATA_W*N_WORDS (512)
//  ARM_CYCLES      2     cycles pe_en is high with pe_rst_n still low before release (>=1)
//  TIMEOUT_CYCLES  4096  RUN-state watchdog limit; used only with ATTN_LOADER_TIMEOUT_EN
// PORTS
//  clk          in   1        single clock, all logic on posedge
//  rst_n        in   1        asynchronous active-low reset
//  start        in   1        1-cycle request to begin a load; honoured only in IDLE
//  in_data      in   DATA_W   stream word
//  in_valid     in   1        in_data valid
//  in_ready     out  1        loader accepts word this cycle (transfer = in_valid & in_ready)
//  key          out  512      word i at [i*16+:16]
//  query        out  512      word i at [i*16+:16]
//  value        out  512      word i at [i*16+:16]
//  pe_en        out  1        to pe_8x8_top.en
//  pe_rst_n     out  1        to pe_8x8_top.rst_n, driven from a flop
//  pe_all_done  in   1        from pe_8x8_top.all_done
//  busy         out  1        high in any state except IDLE
//  done         out  1        1-cycle pulse when a run completes (or times out)
//  timeout      out  1        1-cycle pulse with done on watchdog expiry; tied 0 without feature
// BEHAVIOUR
//  Reset: all outputs 0 (buses 0, pe_en=0, pe_rst_n=0, in_ready=0, busy/done/timeout=0); state=IDLE; cnt=0.
//  FSM IDLE -> LOAD -> ARM -> RUN -> DONE -> IDLE.
//  IDLE
//   - in_ready=0; in_valid ignored; pe_en=0; pe_rst_n=0.
//   - start -> LOAD, cnt<=0. Buses keep the previous contents.
//  LOAD
//   - in_ready=1. Each transfer writes in_data into bank cnt/32 (0=key, 1=query, 2=value) at slot cnt%32.
//   - cnt is 7 bits and increments per transfer.
//   - Transfer at cnt==95 -> ARM. in_ready is 0 from the next cycle onward.
//   - Bubbles (in_valid=0) stall without penalty. No backpressure other than the state.
//  ARM
//   - pe_en=1, pe_rst_n=0 for exactly ARM_CYCLES cycles, then -> RUN.
//   - pe_rst_n rises on the first RUN cycle.
//  RUN
//   - pe_en=1, pe_rst_n=1; buses frozen.
//   - pe_all_done sampled high -> DONE.
//   - pe_all_done high in ARM or LOAD is ignored.
//  DONE
//   - done=1 for one cycle; pe_en<=0, pe_rst_n<=0 on the same edge; -> IDLE.
//   - start in DONE is ignored; a new start is accepted from IDLE onward.
//  start while busy: ignored, no effect on cnt.
//  Async reset mid-operation: immediate return to reset values.
//   - The partially loaded banks are cleared.
//   - pe_rst_n drops asynchronously, so pe_8x8_top is reset as well.
//  Latency: start -> in_ready = 1 cycle; last transfer -> pe_rst_n high = ARM_CYCLES+1 cycles;
//  pe_all_done -> done = 1 cycle.
// CONFIGURATION
//  ATTN_LOADER_TIMEOUT_EN defined:
//   - A 16-bit watchdog counts RUN cycles.
//   - At TIMEOUT_CYCLES without pe_all_done: -> DONE with done=1 and timeout=1 (same cycle).
//   - Watchdog clears on RUN entry.
//  Undefined: no watchdog logic; timeout tied 0; RUN waits indefinitely.
// STRUCTURE
//  Shared package attn_pkg holds:
//   - DATA_W, N_WORDS, BUS_W=DATA_W*N_WORDS
//   - bank indices BANK_KEY=0, BANK_QUERY=1, BANK_VALUE=2
//   - the loader state encoding (3-bit: IDLE, LOAD, ARM, RUN, DONE)
//  Sub-module attn_qkv_bank: one N_WORDS x DATA_W register bank with write-enable and 5-bit slot
//  index, async clear, flat bus output. Instantiated 3x.
// TESTING
//  1 Reset: hold rst_n=0 -> every output 0, busy=0, in_ready=0.
//  2 Load + run:
//    - Stimulus: start, then 96 back-to-back words 16'h0000..16'h005F; stub raises pe_all_done 50 cycles after pe_rst_n rises.
//    - key[15:0]=0000, key[511:496]=001F, query[15:0]=0020, value[511:496]=005F.
//    - pe_rst_n rises ARM_CYCLES+1 cycles after the last transfer.
//    - done pulses once, 1 cycle after pe_all_done.
//  3 Bubbles: in_valid toggled 1/0 every cycle -> identical buses to scenario 2; load takes 191 cycles.
//  4 Ignored inputs:
//    - start during LOAD at cnt=40 -> cnt continues at 41.
//    - in_valid in IDLE -> no write.
//    - pe_all_done pulsed in ARM -> no DONE.
//  5 Reset mid-load: rst_n low at cnt=50 -> buses 0, IDLE. A fresh start plus 96 words completes normally.
//  6 (ATTN_LOADER_TIMEOUT_EN, TIMEOUT_CYCLES=100) pe_all_done never asserted -> done=timeout=1 exactly 100 RUN cycles after entry, pe_en=0 next cycle.

Source files
------------

// File: rtl/attn_pkg.sv
// Shared constants, bank indices and loader state encoding for the QKV operand loader.
package attn_pkg;

    localparam int unsigned DATA_W     = 16;
    localparam int unsigned N_WORDS    = 32;
    localparam int unsigned BUS_W      = DATA_W * N_WORDS;
    localparam int unsigned SLOT_W     = $clog2(N_WORDS);
    localparam int unsigned N_BANKS    = 3;
    localparam int unsigned LOAD_WORDS = N_BANKS * N_WORDS;
    localparam int unsigned CNT_W      = 7;
    localparam int unsigned BANK_SEL_W = CNT_W - SLOT_W;

    localparam int unsigned BANK_KEY   = 0;
    localparam int unsigned BANK_QUERY = 1;
    localparam int unsigned BANK_VALUE = 2;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_ARM  = 3'd2,
        ST_RUN  = 3'd3,
        ST_DONE = 3'd4
    } loader_state_e;

endpackage

// File: rtl/attn_qkv_bank.sv
// One N_WORDS x DATA_W operand register bank: single-slot write port, async clear,
// flat bus output with word i at [i*DATA_W +: DATA_W].
module attn_qkv_bank
    import attn_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [SLOT_W-1:0] slot,
    input  logic [DATA_W-1:0] wdata,
    output logic [BUS_W-1:0]  bus
);

    logic [N_WORDS-1:0][DATA_W-1:0] mem_q;
    logic [N_WORDS-1:0][DATA_W-1:0] mem_d;

    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[slot] = wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

    assign bus = mem_q;

endmodule

// File: rtl/attn_qkv_loader.sv
// Streams 96 words into key/query/value banks, then sequences pe_8x8_top enable/reset
// and holds the buses until all_done. Optional RUN watchdog: ATTN_LOADER_TIMEOUT_EN.
module attn_qkv_loader
    import attn_pkg::*;
#(
    parameter int unsigned ARM_CYCLES = 2
`ifdef ATTN_LOADER_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 4096
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [BUS_W-1:0]  key,
    output logic [BUS_W-1:0]  query,
    output logic [BUS_W-1:0]  value,
    output logic              pe_en,
    output logic              pe_rst_n,
    input  logic              pe_all_done,
    output logic              busy,
    output logic              done,
    output logic              timeout
);

    localparam int unsigned ARM_W = (ARM_CYCLES > 1) ? $clog2(ARM_CYCLES) : 1;

    loader_state_e    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ARM_W-1:0] arm_q, arm_d;
    logic             in_ready_q, in_ready_d;
    logic             pe_en_q, pe_en_d;
    logic             pe_rst_n_q, pe_rst_n_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic                  xfer_c;
    logic [BANK_SEL_W-1:0] bank_sel_c;
    logic [N_BANKS-1:0]    bank_we_c;

`ifdef ATTN_LOADER_TIMEOUT_EN
    localparam int unsigned WD_W = 16;
    logic [WD_W-1:0] wd_q, wd_d;
    logic            timeout_q, timeout_d;
`endif

    // in_ready_q is high exactly while in LOAD
    assign xfer_c     = in_valid & in_ready_q;
    assign bank_sel_c = cnt_q[CNT_W-1:SLOT_W];

    always_comb begin
        bank_we_c = '0;
        for (int b = 0; b < N_BANKS; b++) begin
            bank_we_c[b] = xfer_c && (bank_sel_c == BANK_SEL_W'(b));
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        arm_d   = arm_q;
`ifdef ATTN_LOADER_TIMEOUT_EN
        wd_d      = wd_q;
        timeout_d = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD;
                    cnt_d   = '0;
                end
            end
            ST_LOAD: begin
                if (xfer_c) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(LOAD_WORDS - 1)) begin
                        state_d = ST_ARM;
                        arm_d   = '0;
                    end
                end
            end
            ST_ARM: begin
                if (arm_q == ARM_W'(ARM_CYCLES - 1)) begin
                    state_d = ST_RUN;
`ifdef ATTN_LOADER_TIMEOUT_EN
                    wd_d = '0;
`endif
                end else begin
                    arm_d = arm_q + ARM_W'(1);
                end
            end
            ST_RUN: begin
                if (pe_all_done) begin
                    state_d = ST_DONE;
`ifdef ATTN_LOADER_TIMEOUT_EN
                end else if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d   = ST_DONE;
                    timeout_d = 1'b1;
                end else begin
                    wd_d = wd_q + WD_W'(1);
`endif
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are registered images of the state being entered
        in_ready_d = (state_d == ST_LOAD);
        pe_en_d    = (state_d == ST_ARM) || (state_d == ST_RUN);
        pe_rst_n_d = (state_d == ST_RUN);
        busy_d     = (state_d != ST_IDLE);
        done_d     = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            arm_q      <= '0;
            in_ready_q <= 1'b0;
            pe_en_q    <= 1'b0;
            pe_rst_n_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            arm_q      <= arm_d;
            in_ready_q <= in_ready_d;
            pe_en_q    <= pe_en_d;
            pe_rst_n_q <= pe_rst_n_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

`ifdef ATTN_LOADER_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_q      <= wd_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    assign in_ready = in_ready_q;
    assign pe_en    = pe_en_q;
    assign pe_rst_n = pe_rst_n_q;
    assign busy     = busy_q;
    assign done     = done_q;

    attn_qkv_bank u_bank_key (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (bank_we_c[BANK_KEY]),
        .slot  (cnt_q[SLOT_W-1:0]),
        .wdata (in_data),
        .bus   (key)
    );

    attn_qkv_bank u_bank_query (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (bank_we_c[BANK_QUERY]),
        .slot  (cnt_q[SLOT_W-1:0]),
        .wdata (in_data),
        .bus   (query)
    );

    attn_qkv_bank u_bank_value (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (bank_we_c[BANK_VALUE]),
        .slot  (cnt_q[SLOT_W-1:0]),
        .wdata (in_data),
        .bus   (value)
    );

endmodule
